rc4_stream_xor: RTL
===================

# rc4_stream_xor

Downstream stage of the RC4 keystream generator. Buffers generated keystream bytes in a small FIFO and XORs them, in order, with a byte stream of plaintext or ciphertext of programmable length. Produces the result on a valid/ready output stream. Keystream position carries over between messages, so one long RC4 stream can cover several consecutive messages.

## Interface
Parameters:
- KS_DEPTH, 4, keystream FIFO depth in bytes; power of two, at least 2
- LEN_W, 16, width of the message length and byte counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a message; honoured only in IDLE
- msg_len  in  LEN_W  message length in bytes; sampled when start is honoured
- ks_flush  in  1  synchronous clear of the keystream FIFO; use on rekey
- ks_valid  in  1  keystream byte offered
- ks_data  in  8  keystream byte
- ks_ready  out  1  FIFO not full
- din_valid  in  1  input data byte offered
- din_data  in  8  input data byte
- din_ready  out  1  input byte will be consumed this cycle if din_valid is high
- dout_valid  out  1  output byte held
- dout_data  out  8  din_data XOR keystream byte
- dout_ready  in  1  downstream accepts dout this cycle
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a message completes

## Operation
- States:
  - IDLE to RUN on start when msg_len != 0.
  - IDLE to DONE on start when msg_len == 0.
  - RUN to DONE on the cycle where the last output byte handshakes (dout_valid & dout_ready and out_cnt == len-1).
  - DONE to IDLE unconditionally after one cycle; done = (state == DONE).
- start outside IDLE is ignored. msg_len is latched into len_q when start is honoured.
- Keystream FIFO:
  - write = ks_valid & ks_ready; ks_ready = !full. The FIFO accepts writes in every state.
  - Read pointer advances only on an input consume.
  - Leftover bytes stay queued for the next message.
  - Pointers are LOG2(KS_DEPTH)+1 bits wide and wrap modulo 2·KS_DEPTH. full/empty are derived from MSB difference.
  - Simultaneous read and write when full: the read frees the slot, but ks_ready is still low that cycle because it is computed from the current state. No overflow or underflow is possible.
- ks_flush clears both FIFO pointers on the next edge and takes priority over any write or read in the same cycle. It is legal only in IDLE; in RUN it is ignored.
- Input consume (din_valid & din_ready) requires all of:
  - state == RUN
  - FIFO not empty
  - in_cnt < len_q
  - output register free (!dout_valid | dout_ready)
- On consume:
  - dout_data <= din_data ^ fifo[rd_ptr]
  - dout_valid <= 1
  - in_cnt increments
- Output register:
  - dout_valid clears on handshake unless it is reloaded in the same cycle.
  - dout_data is held stable while dout_valid & !dout_ready.
  - out_cnt increments on each output handshake.
- in_cnt and out_cnt reset to 0 when start is honoured. Both are LEN_W bits; len_q never exceeds 2^LEN_W-1, so neither counter wraps.
- Reset values: ks_ready=1, din_ready=0, dout_valid=0, dout_data=0, busy=0, done=0, state IDLE, FIFO empty, counters 0.
- Reset mid-message aborts the message. FIFO contents are discarded and no done is pulsed.

## Timing
- Keystream written at edge t is usable for a consume in cycle t+1.
- Latency from input consume in cycle t to dout_valid: 1 cycle (visible after edge t).
- Throughput is 1 byte/cycle sustained when the FIFO is non-empty and dout_ready is held high.
- din_ready is combinational from state, FIFO empty, counters, dout_valid and dout_ready. It does not depend on din_valid.
- done pulses in the cycle after the final output handshake. busy falls at the same edge. For msg_len=0, done is high in the cycle after start.
- A new start is honoured no earlier than the cycle after done.

## Test plan
- Basic: preload keystream 0x11,0x22,0x33; start msg_len=3; din 0xA0,0xB0,0xC0 -> dout 0xB1,0x92,0xF3, one per cycle; done 1 cycle after the 3rd handshake.
- Backpressure: same stimulus with dout_ready low for 3 cycles on byte 2 -> dout_data held at 0x92; din_ready low while the register is full; no bytes lost or duplicated.
- Keystream starvation/FIFO full: withhold ks_valid during RUN -> din_ready=0 until a byte arrives. Separately, push 5 bytes with KS_DEPTH=4 and no reads -> ks_ready low after the 4th write; the 5th is accepted only after a read.
- Carry-over and flush: msg_len=2 with 4 keystream bytes queued; the next message uses bytes 3,4. Repeat with ks_flush in IDLE -> the FIFO is empty and the next message stalls until new keystream arrives.
- Zero length and ignored start: start with msg_len=0 -> done next cycle with no din_ready. A second start during RUN -> no effect on len_q or the counters.
- Async reset mid-message: assert rst_n low after 2 of 5 bytes -> all outputs at reset values immediately; no done; a fresh message after reset runs correctly.

Source files
------------

// File: rtl/rc4_stream_xor.sv
// RC4 keystream combiner: buffers keystream bytes in a small FIFO and XORs them
// in order with a length-delimited data byte stream onto a valid/ready output.
`timescale 1ns/1ps
module rc4_stream_xor #(
    parameter int unsigned KS_DEPTH = 4,
    parameter int unsigned LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             ks_flush,
    input  logic             ks_valid,
    input  logic [7:0]       ks_data,
    output logic             ks_ready,
    input  logic             din_valid,
    input  logic [7:0]       din_data,
    output logic             din_ready,
    output logic             dout_valid,
    output logic [7:0]       dout_data,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned AW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q,      state_d;
    logic [LEN_W-1:0] len_q,        len_d;
    logic [LEN_W-1:0] in_cnt_q,     in_cnt_d;
    logic [LEN_W-1:0] out_cnt_q,    out_cnt_d;
    logic [PW-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q,     rd_ptr_d;
    logic [7:0]       mem_q [KS_DEPTH];
    logic [7:0]       mem_d [KS_DEPTH];
    logic             dout_valid_q, dout_valid_d;
    logic [7:0]       dout_data_q,  dout_data_d;

    logic fifo_full;
    logic fifo_empty;
    logic flush_en;
    logic ks_wr;
    logic consume;
    logic out_hs;
    logic last_hs;

    // FIFO status, handshake qualifiers and status outputs decoded from registered state
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        flush_en   = ks_flush && (state_q == ST_IDLE);
        ks_ready   = !fifo_full;
        ks_wr      = ks_valid && !fifo_full && !flush_en;
        din_ready  = (state_q == ST_RUN) && !fifo_empty && (in_cnt_q < len_q) &&
                     (!dout_valid_q || dout_ready);
        consume    = din_valid && din_ready;
        out_hs     = dout_valid_q && dout_ready;
        last_hs    = out_hs && (out_cnt_q == (len_q - LEN_W'(1)));
        busy       = (state_q == ST_RUN);
        done       = (state_q == ST_DONE);
        dout_valid = dout_valid_q;
        dout_data  = dout_data_q;
    end

    // Next-state logic for the message FSM, counters, FIFO and output register
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_d        = mem_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = msg_len;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (msg_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (last_hs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Keystream FIFO: flush wins over any write in the same cycle
        if (flush_en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (ks_wr) begin
                mem_d[wr_ptr_q[AW-1:0]] = ks_data;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (consume) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end

        // Output register: a reload in the same cycle as a handshake keeps valid high
        if (out_hs) begin
            dout_valid_d = 1'b0;
            out_cnt_d    = out_cnt_q + LEN_W'(1);
        end
        if (consume) begin
            dout_valid_d = 1'b1;
            dout_data_d  = din_data ^ mem_q[rd_ptr_q[AW-1:0]];
            in_cnt_d     = in_cnt_q + LEN_W'(1);
        end
    end

    // State register; reset discards the FIFO and any message in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            for (int i = 0; i < int'(KS_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            mem_q        <= mem_d;
        end
    end

endmodule
